dm_sba_ctrl: RTL and testbench



---
 rtl/dm_sba_ctrl_if.sv | 25 ++
 rtl/dm_sba_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_dm_sba_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_sba_ctrl_if.sv
// Bus master port of the debug-module system bus access engine:
// req/gnt request handshake followed by an r_valid qualified response.
interface dm_sba_ctrl_if #(
  parameter int BusWidth = 32
);
  logic                  req;
  logic [BusWidth-1:0]   add;
  logic                  we;
  logic [BusWidth-1:0]   wdata;
  logic [BusWidth/8-1:0] be;
  logic                  gnt;
  logic                  r_valid;
  logic                  r_err;
  logic [BusWidth-1:0]   r_rdata;

  modport master (
    output req, add, we, wdata, be,
    input  gnt, r_valid, r_err, r_rdata
  );

  modport slave (
    input  req, add, we, wdata, be,
    output gnt, r_valid, r_err, r_rdata
  );
endinterface

// File: rtl/dm_sba_ctrl.sv
// System bus access engine for the RISC-V debug module: launches one lane-aligned
// bus transaction per debugger trigger and reports data, auto-increment and faults.
module dm_sba_ctrl #(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                dmactive_i,
  dm_sba_ctrl_if.master       master,
  input  logic [BusWidth-1:0] sbaddress_i,
  input  logic                sbaddress_write_valid_i,
  input  logic                sbreadonaddr_i,
  input  logic                sbautoincrement_i,
  input  logic [2:0]          sbaccess_i,
  input  logic                sbreadondata_i,
  input  logic [BusWidth-1:0] sbdata_i,
  input  logic                sbdata_read_valid_i,
  input  logic                sbdata_write_valid_i,
  output logic [BusWidth-1:0] sbdata_o,
  output logic                sbdata_valid_o,
  output logic [BusWidth-1:0] sbaddress_o,
  output logic                sbaddress_valid_o,
  output logic                sbbusy_o,
  output logic                sbbusyerror_o,
  output logic                sberror_valid_o,
  output logic [2:0]          sberror_o
);

  localparam int BeW             = BusWidth / 8;
  localparam int OffW            = $clog2(BeW);
  localparam logic [2:0] MaxAcc  = 3'(OffW);
  localparam bit TimeoutEn       = (TimeoutCycles > 0);
  localparam int CntW            = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutEn ? TimeoutCycles - 1 : 0);

  typedef enum logic [1:0] {Idle, Req, Wait, Drain} state_e;

  state_e              state_q;
  logic [CntW-1:0]     cnt_q;
  logic [BusWidth-1:0] addr_q;
  logic [BusWidth-1:0] wdata_q;
  logic                we_q;
  logic [2:0]          acc_q;
  logic [BeW-1:0]      be_q;
  logic                req_q;
  logic [BusWidth-1:0] sbdata_q;
  logic [BusWidth-1:0] sbaddress_q;
  logic                sbdata_valid_q;
  logic                sbaddress_valid_q;
  logic                busyerr_q;
  logic                err_valid_q;
  logic [2:0]          err_q;

  logic                write_trig;
  logic                read_trig;
  logic                any_trig;
  logic                size_err;
  logic                align_err;
  logic                resp_fire;
  logic                timeout_hit;
  logic [OffW-1:0]     offset_d;
  logic [OffW-1:0]     offset_q;
  logic [BeW-1:0]      be_d;
  logic [BusWidth-1:0] wdata_d;
  logic [BusWidth-1:0] rdata_lane;
  logic [BusWidth-1:0] sbaddress_d;

  assign write_trig = sbdata_write_valid_i;
  assign read_trig  = (sbdata_read_valid_i && sbreadondata_i) ||
                      (sbaddress_write_valid_i && sbreadonaddr_i);
  assign any_trig   = write_trig || read_trig;

  assign size_err   = (sbaccess_i > MaxAcc);
  assign align_err  = |(sbaddress_i & ((BusWidth'(1) << sbaccess_i) - BusWidth'(1)));

  // A full-width access shifts the one out of range, so the minus one yields all ones.
  assign offset_d   = sbaddress_i[OffW-1:0];
  assign be_d       = ((BeW'(1) << (8'd1 << sbaccess_i)) - BeW'(1)) << offset_d;
  assign wdata_d    = sbdata_i << {offset_d, 3'b000};

  assign offset_q    = addr_q[OffW-1:0];
  assign rdata_lane  = (master.r_rdata >> {offset_q, 3'b000}) &
                       ((BusWidth'(1) << (8'd8 << acc_q)) - BusWidth'(1));
  assign sbaddress_d = addr_q + (BusWidth'(1) << acc_q);

  // A grant and response in the same Req cycle completes the transaction directly.
  assign resp_fire   = master.r_valid &&
                       ((state_q == Wait) || ((state_q == Req) && master.gnt));
  assign timeout_hit = TimeoutEn && (cnt_q == CntLast);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= Idle;
      cnt_q             <= '0;
      addr_q            <= '0;
      wdata_q           <= '0;
      we_q              <= 1'b0;
      acc_q             <= '0;
      be_q              <= '0;
      req_q             <= 1'b0;
      sbdata_q          <= '0;
      sbaddress_q       <= '0;
      sbdata_valid_q    <= 1'b0;
      sbaddress_valid_q <= 1'b0;
      busyerr_q         <= 1'b0;
      err_valid_q       <= 1'b0;
      err_q             <= '0;
    end else if (!dmactive_i) begin
      state_q           <= Idle;
      cnt_q             <= '0;
      addr_q            <= '0;
      wdata_q           <= '0;
      we_q              <= 1'b0;
      acc_q             <= '0;
      be_q              <= '0;
      req_q             <= 1'b0;
      sbdata_q          <= '0;
      sbaddress_q       <= '0;
      sbdata_valid_q    <= 1'b0;
      sbaddress_valid_q <= 1'b0;
      busyerr_q         <= 1'b0;
      err_valid_q       <= 1'b0;
      err_q             <= '0;
    end else begin
      sbdata_valid_q    <= 1'b0;
      sbaddress_valid_q <= 1'b0;
      err_valid_q       <= 1'b0;
      busyerr_q         <= any_trig && (state_q != Idle);

      if (resp_fire) begin
        state_q <= Idle;
        cnt_q   <= '0;
        req_q   <= 1'b0;
        if (master.r_err) begin
          err_valid_q <= 1'b1;
          err_q       <= 3'd2;
        end else begin
          if (!we_q) begin
            sbdata_q       <= rdata_lane;
            sbdata_valid_q <= 1'b1;
          end
          if (sbautoincrement_i) begin
            sbaddress_q       <= sbaddress_d;
            sbaddress_valid_q <= 1'b1;
          end
        end
      end else begin
        unique case (state_q)
          Idle: begin
            cnt_q <= '0;
            if (any_trig) begin
              if (size_err) begin
                err_valid_q <= 1'b1;
                err_q       <= 3'd4;
              end else if (align_err) begin
                err_valid_q <= 1'b1;
                err_q       <= 3'd3;
              end else begin
                state_q <= Req;
                req_q   <= 1'b1;
                addr_q  <= sbaddress_i;
                acc_q   <= sbaccess_i;
                we_q    <= write_trig;
                be_q    <= be_d;
                wdata_q <= wdata_d;
              end
            end
          end
          Req: begin
            if (master.gnt) begin
              state_q <= Wait;
              cnt_q   <= '0;
              req_q   <= 1'b0;
            end else if (timeout_hit) begin
              state_q     <= Idle;
              cnt_q       <= '0;
              req_q       <= 1'b0;
              err_valid_q <= 1'b1;
              err_q       <= 3'd1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          Wait: begin
            // The late response is still owed by the bus, so Drain absorbs it.
            if (timeout_hit) begin
              state_q     <= Drain;
              cnt_q       <= '0;
              err_valid_q <= 1'b1;
              err_q       <= 3'd1;
            end else begin
              cnt_q <= cnt_q + CntW'(1);
            end
          end
          Drain: begin
            if (master.r_valid) begin
              state_q <= Idle;
            end
          end
          default: state_q <= Idle;
        endcase
      end
    end
  end

  assign master.req        = req_q;
  assign master.add        = addr_q;
  assign master.we         = we_q;
  assign master.be         = be_q;
  assign master.wdata      = wdata_q;

  assign sbdata_o          = sbdata_q;
  assign sbdata_valid_o    = sbdata_valid_q;
  assign sbaddress_o       = sbaddress_q;
  assign sbaddress_valid_o = sbaddress_valid_q;
  assign sbbusy_o          = (state_q != Idle);
  assign sbbusyerror_o     = busyerr_q;
  assign sberror_valid_o   = err_valid_q;
  assign sberror_o         = err_q;

endmodule

// File: tb/tb_dm_sba_ctrl.sv
// Scoreboard bench for dm_sba_ctrl: stimulus pushes expected events computed from a
// byte-level model; a negedge monitor pops and compares whatever the DUT presents.
module tb_dm_sba_ctrl;

  localparam int BW     = 32;
  localparam int TO     = 4;
  localparam int BeW    = BW / 8;
  localparam int MaxAcc = $clog2(BeW);

  typedef enum int {EvReq, EvBusyErr, EvErr, EvData, EvAddr} ev_e;

  typedef struct {
    ev_e            kind;
    logic [BW-1:0]  add;
    logic           we;
    logic [BeW-1:0] be;
    logic [BW-1:0]  val;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          dmactive;
  logic [BW-1:0] sbaddress;
  logic          sbaddrWriteValid;
  logic          sbreadonaddr;
  logic          sbautoinc;
  logic [2:0]    sbaccess;
  logic          sbreadondata;
  logic [BW-1:0] sbdataIn;
  logic          sbdataReadValid;
  logic          sbdataWriteValid;
  logic [BW-1:0] sbdataOut;
  logic          sbdataValid;
  logic [BW-1:0] sbaddressOut;
  logic          sbaddressValid;
  logic          sbbusy;
  logic          sbbusyerror;
  logic          sberrorValid;
  logic [2:0]    sberror;

  int   checks = 0;
  int   errors = 0;
  exp_t expQ[$];

  dm_sba_ctrl_if #(.BusWidth(BW)) bus ();

  dm_sba_ctrl #(.BusWidth(BW), .TimeoutCycles(TO)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .dmactive_i              (dmactive),
    .master                  (bus),
    .sbaddress_i             (sbaddress),
    .sbaddress_write_valid_i (sbaddrWriteValid),
    .sbreadonaddr_i          (sbreadonaddr),
    .sbautoincrement_i       (sbautoinc),
    .sbaccess_i              (sbaccess),
    .sbreadondata_i          (sbreadondata),
    .sbdata_i                (sbdataIn),
    .sbdata_read_valid_i     (sbdataReadValid),
    .sbdata_write_valid_i    (sbdataWriteValid),
    .sbdata_o                (sbdataOut),
    .sbdata_valid_o          (sbdataValid),
    .sbaddress_o             (sbaddressOut),
    .sbaddress_valid_o       (sbaddressValid),
    .sbbusy_o                (sbbusy),
    .sbbusyerror_o           (sbbusyerror),
    .sberror_valid_o         (sberrorValid),
    .sberror_o               (sberror)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Byte-level reference: byte b of the bus belongs to the access when it lies in [off, off+size).
  function automatic logic [BeW-1:0] modelBe(input logic [BW-1:0] a, input int size);
    int off;
    off = int'(a % BeW);
    modelBe = '0;
    for (int b = 0; b < BeW; b++)
      if (b >= off && b < off + size) modelBe[b] = 1'b1;
  endfunction

  function automatic logic [BW-1:0] modelWdata(input logic [BW-1:0] d, input logic [BW-1:0] a);
    int off;
    off = int'(a % BeW);
    modelWdata = '0;
    for (int b = off; b < BeW; b++) modelWdata[8*b +: 8] = d[8*(b-off) +: 8];
  endfunction

  function automatic logic [BW-1:0] modelRdata(input logic [BW-1:0] rd, input logic [BW-1:0] a,
                                               input int size);
    int off;
    off = int'(a % BeW);
    modelRdata = '0;
    for (int k = 0; k < size && off + k < BeW; k++) modelRdata[8*k +: 8] = rd[8*(off+k) +: 8];
  endfunction

  task automatic pushEv(input ev_e k, input logic [BW-1:0] v);
    exp_t e;
    e.kind = k; e.add = '0; e.we = 1'b0; e.be = '0; e.val = v;
    expQ.push_back(e);
  endtask

  task automatic pushReq(input bit we, input logic [BW-1:0] a, input int size, input logic [BW-1:0] d);
    exp_t e;
    e.kind = EvReq; e.add = a; e.we = we; e.be = modelBe(a, size); e.val = modelWdata(d, a);
    expQ.push_back(e);
  endtask

  task automatic popExpect(input ev_e k, input string name, output exp_t e, output bit ok);
    ok = 1'b0;
    e.kind = EvReq; e.add = '0; e.we = 1'b0; e.be = '0; e.val = '0;
    if (expQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected %s: got event %0d, expected none", name, int'(k));
    end else begin
      e  = expQ.pop_front();
      ok = (e.kind == k);
      checkOutput({name, " event kind"}, 64'(int'(k)), 64'(int'(e.kind)));
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   ok;
    static bit   reqPrev  = 1'b0;
    static bit   reqValid = 1'b0;
    static exp_t curReq;
    if (!rst) begin
      if (bus.req) begin
        if (!reqPrev) begin
          popExpect(EvReq, "bus request", e, ok);
          reqValid = ok;
          curReq   = e;
        end
        if (reqValid) begin
          checkOutput("req add",   64'(bus.add),   64'(curReq.add));
          checkOutput("req we",    64'(bus.we),    64'(curReq.we));
          checkOutput("req be",    64'(bus.be),    64'(curReq.be));
          checkOutput("req wdata", 64'(bus.wdata), 64'(curReq.val));
        end
      end
      reqPrev = bus.req;
      if (sbbusyerror) popExpect(EvBusyErr, "busy error", e, ok);
      if (sberrorValid) begin
        popExpect(EvErr, "sberror strobe", e, ok);
        if (ok) checkOutput("sberror", 64'(sberror), 64'(e.val));
      end
      if (sbdataValid) begin
        popExpect(EvData, "sbdata strobe", e, ok);
        if (ok) checkOutput("sbdata", 64'(sbdataOut), 64'(e.val));
      end
      if (sbaddressValid) begin
        popExpect(EvAddr, "sbaddress strobe", e, ok);
        if (ok) checkOutput("sbaddress", 64'(sbaddressOut), 64'(e.val));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // trig: 0 write, 1 read-on-data, 2 read-on-address, 3 write and read together.
  task automatic fireTrigger(input int trig, input logic [BW-1:0] a, input logic [2:0] acc,
                             input logic [BW-1:0] d);
    sbaddress = a; sbaccess = acc; sbdataIn = d;
    sbdataWriteValid = (trig == 0 || trig == 3);
    sbdataReadValid  = (trig == 1 || trig == 3);
    sbreadondata     = (trig == 1 || trig == 3);
    sbaddrWriteValid = (trig == 2);
    sbreadonaddr     = (trig == 2);
    tick();
    sbdataWriteValid = 1'b0; sbdataReadValid = 1'b0; sbreadondata = 1'b0;
    sbaddrWriteValid = 1'b0; sbreadonaddr = 1'b0;
    sbaddress = $urandom; sbaccess = 3'($urandom); sbdataIn = $urandom;
  endtask

  // rDly < 0 means grant and response arrive in the same cycle.
  task automatic applyStimulus(input bit we, input logic [BW-1:0] a, input logic [2:0] acc,
                               input logic [BW-1:0] d, input bit autoinc, input int trig,
                               input int gDly, input int rDly, input bit rspErr,
                               input logic [BW-1:0] rdata, input bit poke);
    int  size;
    bit  launch;
    size   = 1 << acc;
    launch = 1'b0;
    if (int'(acc) > MaxAcc) pushEv(EvErr, 4);
    else if (a % size != 0) pushEv(EvErr, 3);
    else begin
      launch = 1'b1;
      pushReq(we, a, size, d);
      if (poke && rDly >= 1) pushEv(EvBusyErr, 0);
      if (rspErr) pushEv(EvErr, 2);
      else begin
        if (!we) pushEv(EvData, modelRdata(rdata, a, size));
        if (autoinc) pushEv(EvAddr, a + BW'(size));
      end
    end
    sbautoinc = autoinc;
    fireTrigger(trig, a, acc, d);
    if (launch) begin
      repeat (gDly) tick();
      bus.gnt = 1'b1;
      if (rDly < 0) begin
        bus.r_valid = 1'b1; bus.r_err = rspErr; bus.r_rdata = rdata;
      end
      tick();
      bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_err = 1'b0;
      if (rDly >= 0) begin
        for (int i = 0; i < rDly; i++) begin
          if (i == 0 && poke) sbdataWriteValid = 1'b1;
          tick();
          sbdataWriteValid = 1'b0;
        end
        bus.r_valid = 1'b1; bus.r_err = rspErr; bus.r_rdata = rdata;
        tick();
        bus.r_valid = 1'b0; bus.r_err = 1'b0;
      end
      bus.r_rdata = $urandom;
    end
    repeat (2) tick();
  endtask

  initial begin
    int reqCycles;
    rst = 1'b1; dmactive = 1'b1;
    sbaddress = '0; sbaddrWriteValid = 1'b0; sbreadonaddr = 1'b0; sbautoinc = 1'b0;
    sbaccess = '0; sbreadondata = 1'b0; sbdataIn = '0; sbdataReadValid = 1'b0;
    sbdataWriteValid = 1'b0;
    bus.gnt = 1'b0; bus.r_valid = 1'b0; bus.r_err = 1'b0; bus.r_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset req",       64'(bus.req),      0);
    checkOutput("reset busy",      64'(sbbusy),       0);
    checkOutput("reset sbdata",    64'(sbdataOut),    0);
    checkOutput("reset sbaddress", 64'(sbaddressOut), 0);
    checkOutput("reset sberror",   64'(sberror),      0);
    checkOutput("reset strobes",   64'({sbdataValid, sbaddressValid, sbbusyerror, sberrorValid}), 0);
    rst = 1'b0;
    repeat (2) tick();

    $display("[TB] directed cases");
    applyStimulus(0, 32'h0000_1003, 0, 32'h0, 0, 1, 1, 1, 0, 32'hAABB_CCDD, 0);
    applyStimulus(1, 32'h0000_0104, 2, 32'h1234_5678, 1, 0, 0, 0, 0, 32'h0, 0);
    checkOutput("sbdata held over write", 64'(sbdataOut), 64'h0000_00AA);
    applyStimulus(0, 32'h0000_0003, 1, 32'h0, 0, 2, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0000_0000, 3'(MaxAcc + 1), 32'h0, 0, 1, 0, 0, 0, 32'h0, 0);
    applyStimulus(0, 32'h0000_2002, 1, 32'h0, 0, 1, 0, 1, 0, 32'h1122_3344, 0);
    checkOutput("sberror held", 64'(sberror), 4);
    applyStimulus(0, 32'h0000_3000, 2, 32'h0, 1, 1, 0, 0, 1, 32'hDEAD_BEEF, 0);
    applyStimulus(1, 32'h0000_4001, 0, 32'h0000_00C3, 0, 0, 0, 2, 0, 32'h0, 1);
    applyStimulus(0, 32'h0000_5006, 1, 32'h0, 1, 2, 0, -1, 0, 32'h8765_4321, 0);
    applyStimulus(1, 32'h0000_6004, 2, 32'hCAFE_F00D, 0, 3, 1, 0, 0, 32'h0, 0);
    applyStimulus(1, 32'hFFFF_FFFC, 2, 32'h0102_0304, 1, 0, 0, 0, 0, 32'h0, 0);

    // Request phase never granted.
    pushReq(0, 32'h0000_7000, 4, 32'h0);
    pushEv(EvErr, 1);
    fireTrigger(1, 32'h0000_7000, 2, 32'h0);
    reqCycles = 0;
    for (int i = 0; i < 8; i++) begin
      if (bus.req) reqCycles++;
      tick();
    end
    checkOutput("req cycles before timeout", 64'(reqCycles), 64'(TO));

    // Granted but the response is late; it must be swallowed.
    pushReq(0, 32'h0000_7100, 4, 32'h0);
    pushEv(EvErr, 1);
    fireTrigger(1, 32'h0000_7100, 2, 32'h0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    repeat (TO) tick();
    checkOutput("busy while draining", 64'(sbbusy), 1);
    bus.r_valid = 1'b1; bus.r_rdata = 32'h5555_AAAA;
    tick();
    bus.r_valid = 1'b0;
    checkOutput("busy after drain", 64'(sbbusy), 0);
    repeat (2) tick();

    // dmactive low abandons the transaction in Wait.
    pushReq(0, 32'h0000_8000, 4, 32'h0);
    fireTrigger(2, 32'h0000_8000, 2, 32'h0);
    bus.gnt = 1'b1;
    tick();
    bus.gnt = 1'b0;
    dmactive = 1'b0;
    tick();
    dmactive = 1'b1;
    checkOutput("req after dmactive clear",    64'(bus.req),   0);
    checkOutput("busy after dmactive clear",   64'(sbbusy),    0);
    checkOutput("sbdata after dmactive clear", 64'(sbdataOut), 0);
    repeat (3) tick();

    // Read triggers without their enables start nothing.
    sbdataReadValid = 1'b1; sbaddrWriteValid = 1'b1;
    tick();
    sbdataReadValid = 1'b0; sbaddrWriteValid = 1'b0;
    repeat (3) tick();

    $display("[TB] randomized cases");
    for (int n = 0; n < 60; n++) begin
      bit            we;
      logic [2:0]    acc;
      logic [BW-1:0] addr;
      int            trig;
      we   = 1'($urandom_range(0, 1));
      acc  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(MaxAcc + 1, 7))
                                         : 3'($urandom_range(0, MaxAcc));
      addr = $urandom;
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFF0 | (addr & 32'hF);
      if (int'(acc) <= MaxAcc && $urandom_range(0, 3) != 0)
        addr = addr & ~BW'((1 << acc) - 1);
      trig = we ? ($urandom_range(0, 1) ? 3 : 0) : int'($urandom_range(1, 2));
      applyStimulus(we, addr, acc, $urandom, 1'($urandom_range(0, 1)), trig,
                    int'($urandom_range(0, 2)), int'($urandom_range(0, 3)) - 1,
                    ($urandom_range(0, 5) == 0), $urandom, 1'($urandom_range(0, 1)));
    end

    repeat (5) tick();
    checkOutput("outstanding expectations", 64'(expQ.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
